mem_port_arbiter: RTL and testbench

//  Shares one single-port memory_unit between instruction fetch (read-only) and the data

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_arb_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//  arb_state_e : access sequencer states
//  arb_owner_e : which requester owns the outstanding read
//  LAT_CNT_W   : width of the read latency counter (READ_LAT up to 2**LAT_CNT_W)
package mem_arb_pkg;

  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-path and memory signals around the arbiter.
//  master : requesters plus memory (drives requests and mem_rdata)
//  slave  : the arbiter (drives grants, responses and memory command)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of fetch arbitrations lost in a row.
//  clk, clr   : clock, async active-high reset
//  arb_en_i   : arbitration is possible this cycle (IDLE/RESP)
//  if_req_i   : fetch is requesting
//  if_gnt_i   : fetch was granted this cycle
//  force_if_o : fetch has waited MAX_WAIT times and must win next
module mem_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic force_if_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Holds its value outside arbitration cycles so RD_WAIT does not count as a loss.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (if_gnt_i) begin
      cnt_q <= '0;
    end else if (arb_en_i && if_req_i && (cnt_q != CNT_W'(MAX_WAIT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign force_if_o = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
//  clk  : clock, rising edge
//  clr  : async active-high reset; drops any access in flight
//  bus  : slave side of mem_port_arbiter_if (fetch, data, memory, busy)
// Grants and the memory command are combinational from the winner; responses
// (rvalid/rdata) and busy come from registers.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              clr,
  mem_port_arbiter_if.slave bus
);

  arb_state_e           state_q;
  arb_owner_e           owner_q;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 if_rvalid_q;
  logic                 dm_rvalid_q;
  logic [DATA_W-1:0]    if_rdata_q;
  logic [DATA_W-1:0]    dm_rdata_q;

  logic arb_en;
  logic force_if;
  logic dm_win;
  logic if_win;

  // Arbitration: data wins unless fetch has been starved; gated by clr so
  // every output reads 0 while reset is asserted.
  always_comb begin
    arb_en = 1'b0;
    dm_win = 1'b0;
    if_win = 1'b0;
    arb_en = !clr && ((state_q == ARB_IDLE) || (state_q == ARB_RESP));
    dm_win = arb_en && bus.dm_req && !(force_if && bus.if_req);
    if_win = arb_en && bus.if_req && !dm_win;
  end

  mem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk        (clk),
    .clr        (clr),
    .arb_en_i   (arb_en),
    .if_req_i   (bus.if_req),
    .if_gnt_i   (if_win),
    .force_if_o (force_if)
  );

  // Access sequencer: grant -> (RD_WAIT x READ_LAT) -> RESP, or grant -> RESP for stores.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      lat_cnt_q   <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state_q)
        ARB_RD_WAIT: begin
          if (lat_cnt_q == '0) begin
            // Last latency edge: mem_rdata is valid now.
            state_q <= ARB_RESP;
            if (owner_q == OWN_IF) begin
              if_rdata_q  <= bus.mem_rdata;
              if_rvalid_q <= 1'b1;
            end else begin
              dm_rdata_q  <= bus.mem_rdata;
              dm_rvalid_q <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
          end
        end
        default: begin
          // IDLE and RESP both arbitrate; RESP may chain straight into a new access.
          if (dm_win && bus.dm_we) begin
            state_q     <= ARB_RESP;
            owner_q     <= OWN_DM;
            dm_rvalid_q <= 1'b1;
          end else if (dm_win) begin
            state_q   <= ARB_RD_WAIT;
            owner_q   <= OWN_DM;
            lat_cnt_q <= LAT_CNT_W'(READ_LAT - 1);
          end else if (if_win) begin
            state_q   <= ARB_RD_WAIT;
            owner_q   <= OWN_IF;
            lat_cnt_q <= LAT_CNT_W'(READ_LAT - 1);
          end else begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
          end
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.mem_en    = if_win || dm_win;
  assign bus.mem_wen   = dm_win && bus.dm_we;
  assign bus.mem_addr  = dm_win ? bus.dm_addr : (if_win ? bus.if_addr : ADDR_W'(0));
  assign bus.mem_wdata = dm_win ? bus.dm_wdata : DATA_W'(0);

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u_dut1 uses READ_LAT=1, u_dut3 uses READ_LAT=3, both MAX_WAIT=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .READ_LAT(1), .MAX_WAIT(3)) u_dut1 (
    .clk (clk),
    .clr (clr),
    .bus (b1)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .READ_LAT(3), .MAX_WAIT(3)) u_dut3 (
    .clk (clk),
    .clr (clr),
    .bus (b3)
  );

  // Memory models: latency 1 and latency 3, data valid READ_LAT cycles after the command edge.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1 = 32'h0;
  logic [31:0] s1 = 32'h0, s2 = 32'h0, s3 = 32'h0;

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_wen) mem1[b1.mem_addr] = b1.mem_wdata;
    if (b1.mem_en && !b1.mem_wen) rd1 <= mem1[b1.mem_addr];
  end

  always @(posedge clk) begin
    if (b3.mem_en && b3.mem_wen) mem3[b3.mem_addr] = b3.mem_wdata;
    s1 <= (b3.mem_en && !b3.mem_wen) ? mem3[b3.mem_addr] : 32'h0;
    s2 <= s1;
    s3 <= s2;
  end

  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = s3;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b1.if_req = 1'b1; b1.dm_req = 1'b1; b3.if_req = 1'b1; b3.dm_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b1.if_gnt, b1.dm_gnt, b1.mem_en, b1.mem_wen, b1.if_rvalid, b1.dm_rvalid, b1.busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl1: got %b want 0000000",
        {b1.if_gnt, b1.dm_gnt, b1.mem_en, b1.mem_wen, b1.if_rvalid, b1.dm_rvalid, b1.busy});
    end
    n_cmp++;
    if ({b3.if_gnt, b3.dm_gnt, b3.mem_en, b3.mem_wen, b3.if_rvalid, b3.dm_rvalid, b3.busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl3: got %b want 0000000",
        {b3.if_gnt, b3.dm_gnt, b3.mem_en, b3.mem_wen, b3.if_rvalid, b3.dm_rvalid, b3.busy});
    end
    n_cmp++;
    if ({b1.if_rdata, b1.dm_rdata, b1.mem_addr, b1.mem_wdata} !== 104'h0) begin
      n_err++; $display("FAIL reset_data: got if_rdata=%h dm_rdata=%h mem_addr=%h want 0",
        b1.if_rdata, b1.dm_rdata, b1.mem_addr);
    end
    next_cycle();
    clr = 1'b0;
    b1.if_req = 1'b0; b1.dm_req = 1'b0; b3.if_req = 1'b0; b3.dm_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_lone_fetch();
    b1.if_req = 1'b1; b1.if_addr = 8'h04;
    @(negedge clk);
    n_cmp++;
    if ({b1.if_gnt, b1.dm_gnt, b1.mem_en, b1.mem_wen, b1.busy} !== 5'b10100) begin
      n_err++; $display("FAIL fetch_grant: got gnt/dgnt/en/wen/busy=%b want 10100",
        {b1.if_gnt, b1.dm_gnt, b1.mem_en, b1.mem_wen, b1.busy});
    end
    n_cmp++;
    if (b1.mem_addr !== 8'h04) begin
      n_err++; $display("FAIL fetch_mem_addr: got %h want 04", b1.mem_addr);
    end
    next_cycle();
    b1.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b1.if_gnt, b1.mem_en, b1.if_rvalid, b1.busy} !== 4'b0001) begin
      n_err++; $display("FAIL fetch_wait: got gnt/en/rvalid/busy=%b want 0001",
        {b1.if_gnt, b1.mem_en, b1.if_rvalid, b1.busy});
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({b1.if_rvalid, b1.dm_rvalid, b1.busy} !== 3'b101) begin
      n_err++; $display("FAIL fetch_resp: got rvalid/dvalid/busy=%b want 101",
        {b1.if_rvalid, b1.dm_rvalid, b1.busy});
    end
    n_cmp++;
    if (b1.if_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL fetch_rdata: got %h want deadbeef", b1.if_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({b1.if_rvalid, b1.busy, b1.if_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL fetch_hold: got rvalid=%b busy=%b rdata=%h want 0 0 deadbeef",
        b1.if_rvalid, b1.busy, b1.if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_store_load();
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 8'h10; b1.dm_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if ({b1.dm_gnt, b1.if_gnt, b1.mem_en, b1.mem_wen} !== 4'b1011) begin
      n_err++; $display("FAIL store_grant: got dgnt/igNt/en/wen=%b want 1011",
        {b1.dm_gnt, b1.if_gnt, b1.mem_en, b1.mem_wen});
    end
    n_cmp++;
    if ({b1.mem_addr, b1.mem_wdata} !== {8'h10, 32'h12345678}) begin
      n_err++; $display("FAIL store_cmd: got addr=%h wdata=%h want 10 12345678", b1.mem_addr, b1.mem_wdata);
    end
    next_cycle();
    b1.dm_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b1.dm_rvalid, b1.dm_gnt, b1.mem_en, b1.mem_wen} !== 4'b1110) begin
      n_err++; $display("FAIL store_done_load_grant: got rvalid/gnt/en/wen=%b want 1110",
        {b1.dm_rvalid, b1.dm_gnt, b1.mem_en, b1.mem_wen});
    end
    n_cmp++;
    if (b1.dm_rdata !== 32'h0) begin
      n_err++; $display("FAIL store_no_rdata: got %h want 00000000", b1.dm_rdata);
    end
    n_cmp++;
    if (mem1[8'h10] !== 32'h12345678) begin
      n_err++; $display("FAIL store_mem_write: got %h want 12345678", mem1[8'h10]);
    end
    next_cycle();
    b1.dm_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b1.dm_rvalid, b1.dm_gnt, b1.busy} !== 3'b001) begin
      n_err++; $display("FAIL load_wait: got rvalid/gnt/busy=%b want 001", {b1.dm_rvalid, b1.dm_gnt, b1.busy});
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({b1.dm_rvalid, b1.if_rvalid, b1.dm_rdata} !== {2'b10, 32'h12345678}) begin
      n_err++; $display("FAIL load_resp: got rvalid=%b ivalid=%b rdata=%h want 1 0 12345678",
        b1.dm_rvalid, b1.if_rvalid, b1.dm_rdata);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_if;
    logic [9:0] exp_dm;
    int both_seen;
    exp_if    = 10'h108;  // fetch wins in cycles 3 and 8
    exp_dm    = 10'h0E7;  // data wins in cycles 0-2 and 5-7
    both_seen = 0;
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 8'h20; b1.dm_wdata = 32'h0000_00AA;
    b1.if_req = 1'b1; b1.if_addr = 8'h08;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b1.if_gnt && b1.dm_gnt) both_seen++;
      n_cmp++;
      if ({b1.if_gnt, b1.dm_gnt} !== {exp_if[c], exp_dm[c]}) begin
        n_err++; $display("FAIL starve_order cycle %0d: got if/dm gnt=%b%b want %b%b",
          c, b1.if_gnt, b1.dm_gnt, exp_if[c], exp_dm[c]);
      end
      next_cycle();
    end
    b1.dm_req = 1'b0; b1.if_req = 1'b0; b1.dm_we = 1'b0;
    n_cmp++;
    if (both_seen !== 0) begin
      n_err++; $display("FAIL starve_double_gnt: got %0d cycles with both gnts want 0", both_seen);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_long_load();
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 8'h30;
    @(negedge clk);
    n_cmp++;
    if ({b3.dm_gnt, b3.mem_en, b3.busy} !== 3'b110) begin
      n_err++; $display("FAIL lat3_grant: got gnt/en/busy=%b want 110", {b3.dm_gnt, b3.mem_en, b3.busy});
    end
    next_cycle();
    b3.dm_req = 1'b0; b3.if_req = 1'b1; b3.if_addr = 8'h50;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({b3.busy, b3.if_gnt, b3.dm_gnt, b3.mem_en, b3.dm_rvalid} !== 5'b10000) begin
        n_err++; $display("FAIL lat3_rd_wait cycle %0d: got busy/ign/dgn/en/rv=%b want 10000",
          c, {b3.busy, b3.if_gnt, b3.dm_gnt, b3.mem_en, b3.dm_rvalid});
      end
      next_cycle();
    end
    b3.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b3.dm_rvalid, b3.if_rvalid, b3.busy, b3.dm_rdata} !== {3'b101, 32'hA5A50001}) begin
      n_err++; $display("FAIL lat3_resp: got rv=%b irv=%b busy=%b rdata=%h want 1 0 1 a5a50001",
        b3.dm_rvalid, b3.if_rvalid, b3.busy, b3.dm_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({b3.busy, b3.dm_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL lat3_idle: got busy/rv=%b want 00", {b3.busy, b3.dm_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_clr_mid_fetch();
    int late_rvalid;
    late_rvalid = 0;
    b3.if_req = 1'b1; b3.if_addr = 8'h40;
    @(negedge clk);
    n_cmp++;
    if (b3.if_gnt !== 1'b1) begin
      n_err++; $display("FAIL clr_first_grant: got %b want 1", b3.if_gnt);
    end
    next_cycle();
    b3.if_req = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b3.if_gnt, b3.dm_gnt, b3.mem_en, b3.mem_wen, b3.if_rvalid, b3.dm_rvalid, b3.busy} !== 7'b0) begin
      n_err++; $display("FAIL clr_outputs: got %b want 0000000",
        {b3.if_gnt, b3.dm_gnt, b3.mem_en, b3.mem_wen, b3.if_rvalid, b3.dm_rvalid, b3.busy});
    end
    n_cmp++;
    if ({b3.if_rdata, b3.dm_rdata} !== 64'h0) begin
      n_err++; $display("FAIL clr_rdata: got if=%h dm=%h want 0 0", b3.if_rdata, b3.dm_rdata);
    end
    next_cycle();
    clr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b3.if_rvalid || b3.dm_rvalid || b3.busy) late_rvalid++;
      next_cycle();
    end
    n_cmp++;
    if (late_rvalid !== 0) begin
      n_err++; $display("FAIL clr_dropped: got %0d cycles with rvalid/busy after clr want 0", late_rvalid);
    end
    b3.if_req = 1'b1; b3.if_addr = 8'h44;
    @(negedge clk);
    n_cmp++;
    if ({b3.if_gnt, b3.mem_addr} !== {1'b1, 8'h44}) begin
      n_err++; $display("FAIL clr_refetch_grant: got gnt=%b addr=%h want 1 44", b3.if_gnt, b3.mem_addr);
    end
    next_cycle();
    b3.if_req = 1'b0;
    for (int c = 1; c < 4; c++) next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({b3.if_rvalid, b3.if_rdata} !== {1'b1, 32'h0BADC0DE}) begin
      n_err++; $display("FAIL clr_refetch_resp: got rvalid=%b rdata=%h want 1 0badc0de",
        b3.if_rvalid, b3.if_rdata);
    end
    next_cycle();
  endtask

  initial begin
    b1.if_req = 1'b0; b1.if_addr = 8'h0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    b1.dm_addr = 8'h0; b1.dm_wdata = 32'h0;
    b3.if_req = 1'b0; b3.if_addr = 8'h0; b3.dm_req = 1'b0; b3.dm_we = 1'b0;
    b3.dm_addr = 8'h0; b3.dm_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem1[8'h04] = 32'hDEADBEEF;
    mem3[8'h30] = 32'hA5A50001;
    mem3[8'h40] = 32'hCAFEF00D;
    mem3[8'h44] = 32'h0BADC0DE;
    #1;
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_starvation();
    test_long_load();
    test_clr_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no end of test within 20000 time units, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
